// File: rtl/aes_result_writer_512_if.sv
`default_nettype none
// ============================================================================
// Module      : aes_result_writer_512_if
// Description : Job-control, result-FIFO and memory-write bus bundle for the
//               512-bit AES result writer.
// Revision    : 1.0  initial release
// ============================================================================
interface aes_result_writer_512_if #(
    parameter int DW = 512,
    parameter int AW = 32,
    parameter int LW = 16
);
    logic          cfg_start;
    logic [AW-1:0] cfg_addr;
    logic [LW-1:0] cfg_len;
    logic          busy;
    logic          done;
    logic          err;

    logic          fifo_empty;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_data;

    logic          mem_req;
    logic          mem_req_ack;
    logic [AW-1:0] mem_addr;
    logic [6:0]    mem_blen;
    logic          mem_wvalid;
    logic          mem_wready;
    logic [DW-1:0] mem_wdata;
    logic          mem_wlast;
    logic          mem_bvalid;
    logic          mem_berr;

    // Writer side
    modport master (
        input  cfg_start, cfg_addr, cfg_len, fifo_empty, fifo_data,
               mem_req_ack, mem_wready, mem_bvalid, mem_berr,
        output busy, done, err, fifo_rd_en, mem_req, mem_addr, mem_blen,
               mem_wvalid, mem_wdata, mem_wlast
    );

    // Controller / buffer / memory side
    modport slave (
        output cfg_start, cfg_addr, cfg_len, fifo_empty, fifo_data,
               mem_req_ack, mem_wready, mem_bvalid, mem_berr,
        input  busy, done, err, fifo_rd_en, mem_req, mem_addr, mem_blen,
               mem_wvalid, mem_wdata, mem_wlast
    );
endinterface
`default_nettype wire

// File: rtl/aes_result_writer_512.sv
`default_nettype none
// ============================================================================
// Module      : aes_result_writer_512
// Description : Pops 512-bit result lines and writes them to memory as
//               4 KiB-safe incrementing bursts. Optional per-128-bit-lane byte
//               reversal of write data under AES_RESULT_WRITER_BSWAP_EN.
// Revision    : 1.0  initial release
// ============================================================================
module aes_result_writer_512 #(
    parameter int DW        = 512,
    parameter int AW        = 32,
    parameter int LW        = 16,
    parameter int BURST_MAX = 16
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    aes_result_writer_512_if.master    bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DATA = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t        state_q;
    logic [AW-1:0] addr_q;
    logic [LW-1:0] rem_q;
    logic [6:0]    blen_q;
    logic [6:0]    fetched_q;
    logic [6:0]    sent_q;
    logic [1:0]    ent_q;
    logic          pend_q;
    logic [DW-1:0] skid0_q;
    logic [DW-1:0] skid1_q;
    logic          busy_q;
    logic          done_q;
    logic          err_q;
    logic          req_q;

    logic [AW-1:0] start_addr_d;
    logic [AW-1:0] addr_d;
    logic [6:0]    start_beats_d;
    logic [6:0]    next_beats_d;
    logic          wvalid_d;
    logic          deq_d;
    logic [2:0]    occ_d;
    logic          rd_en_d;

    // Beats in the next burst: BURST_MAX, job remainder, or distance to 4 KiB edge.
    function automatic logic [6:0] f_burst(input logic [5:0] page_beat,
                                           input logic [LW-1:0] rem);
        logic [6:0] b;
        logic [6:0] to4k;
        to4k = 7'd64 - {1'b0, page_beat};
        b    = 7'(BURST_MAX);
        if (to4k < b)
            b = to4k;
        if (rem < LW'(b))
            b = rem[6:0];
        return b;
    endfunction

    assign start_addr_d  = bus.cfg_addr & ~AW'(63);
    assign addr_d        = addr_q + (AW'(blen_q + 7'd1) << 6);
    assign start_beats_d = f_burst(start_addr_d[11:6], bus.cfg_len);
    assign next_beats_d  = f_burst(addr_d[11:6], rem_q);

    // A beat leaving the skid this cycle frees its slot for the read issued now.
    assign wvalid_d = (state_q == S_DATA) && (ent_q != 2'd0);
    assign deq_d    = wvalid_d && bus.mem_wready;
    assign occ_d    = {1'b0, ent_q} + {2'b0, pend_q} - {2'b0, deq_d};
    assign rd_en_d  = (state_q == S_DATA) && !bus.fifo_empty &&
                      (fetched_q <= blen_q) && (occ_d < 3'd2);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            rem_q     <= '0;
            blen_q    <= '0;
            fetched_q <= '0;
            sent_q    <= '0;
            ent_q     <= '0;
            pend_q    <= 1'b0;
            skid0_q   <= '0;
            skid1_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            req_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            pend_q <= rd_en_d;
            if (rd_en_d)
                fetched_q <= fetched_q + 7'd1;
            if (deq_d)
                sent_q <= sent_q + 7'd1;

            if (pend_q && deq_d) begin
                if (ent_q == 2'd2) begin
                    skid0_q <= skid1_q;
                    skid1_q <= bus.fifo_data;
                end else begin
                    skid0_q <= bus.fifo_data;
                end
            end else if (deq_d) begin
                skid0_q <= skid1_q;
                ent_q   <= ent_q - 2'd1;
            end else if (pend_q) begin
                if (ent_q == 2'd0)
                    skid0_q <= bus.fifo_data;
                else
                    skid1_q <= bus.fifo_data;
                ent_q <= ent_q + 2'd1;
            end

            case (state_q)
                S_IDLE: begin
                    // busy lingers through the done cycle so a same-cycle start is refused
                    if (done_q)
                        busy_q <= 1'b0;
                    if (bus.cfg_start && !busy_q && !done_q) begin
                        err_q <= 1'b0;
                        if (bus.cfg_len == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            addr_q  <= start_addr_d;
                            blen_q  <= start_beats_d - 7'd1;
                            rem_q   <= bus.cfg_len - LW'(start_beats_d);
                            req_q   <= 1'b1;
                            busy_q  <= 1'b1;
                            state_q <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (bus.mem_req_ack) begin
                        req_q     <= 1'b0;
                        fetched_q <= '0;
                        sent_q    <= '0;
                        state_q   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (deq_d && (sent_q == blen_q))
                        state_q <= S_RESP;
                end
                S_RESP: begin
                    if (bus.mem_bvalid) begin
                        if (bus.mem_berr || (rem_q == '0)) begin
                            if (bus.mem_berr)
                                err_q <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= S_IDLE;
                        end else begin
                            addr_q  <= addr_d;
                            blen_q  <= next_beats_d - 7'd1;
                            rem_q   <= rem_q - LW'(next_beats_d);
                            req_q   <= 1'b1;
                            state_q <= S_REQ;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign bus.fifo_rd_en = rd_en_d;
    assign bus.mem_req    = req_q;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_blen   = blen_q;
    assign bus.mem_wvalid = wvalid_d;
    assign bus.mem_wlast  = wvalid_d && (sent_q == blen_q);

`ifdef AES_RESULT_WRITER_BSWAP_EN
    for (genvar l = 0; l < DW / 128; l++) begin : g_lane
        for (genvar b = 0; b < 16; b++) begin : g_byte
            assign bus.mem_wdata[l*128 + b*8 +: 8] = skid0_q[l*128 + (15-b)*8 +: 8];
        end
    end
`else
    assign bus.mem_wdata = skid0_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_aes_result_writer_512.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_result_writer_512
// Description : Directed, table-driven bench for aes_result_writer_512.
// Revision    : 1.0  initial release
// ============================================================================
module tb_aes_result_writer_512;
    localparam int DW = 512;
    localparam int AW = 32;
    localparam int LW = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    aes_result_writer_512_if #(.DW(DW), .AW(AW), .LW(LW)) bus ();

    aes_result_writer_512 #(.DW(DW), .AW(AW), .LW(LW), .BURST_MAX(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0]      addr;
        logic [15:0]      len;
        int               wmode;
        int               fmode;
        int               ackdly;
        int               berr_b;
        int               nb;
        logic [3:0][31:0] baddr;
        logic [3:0][6:0]  bblen;
        int               beats;
        logic             err;
    } vec_t;

    vec_t vecs[5];
    int n_chk  = 0;
    int n_pass = 0;

    logic [31:0] got_addr[$];
    logic [6:0]  got_blen[$];
    int   pops, beats, ack_cyc, first_wv, last_hs, done_cnt;
    logic err_at_done;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    task automatic chk_w(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got ..%016h expected ..%016h", nm, act[63:0], exp[63:0]);
    endtask

    function automatic logic [511:0] gen_word(input int k);
        logic [511:0] w;
        for (int j = 0; j < 64; j++) w[j*8 +: 8] = 8'((k * 5 + j) & 255);
        return w;
    endfunction

    function automatic logic [511:0] exp_word(input int k);
        logic [511:0] w;
        logic [511:0] r;
        w = gen_word(k);
`ifdef AES_RESULT_WRITER_BSWAP_EN
        for (int l = 0; l < 4; l++)
            for (int b = 0; b < 16; b++)
                r[l*128 + b*8 +: 8] = w[l*128 + (15-b)*8 +: 8];
`else
        r = w;
`endif
        return r;
    endfunction

    function automatic vec_t mk(input logic [31:0] a, input logic [15:0] len, input int wm,
                                input int fm, input int ad, input int be, input int nb,
                                input int bt, input logic e);
        vec_t v;
        v.addr = a; v.len = len; v.wmode = wm; v.fmode = fm; v.ackdly = ad;
        v.berr_b = be; v.nb = nb; v.beats = bt; v.err = e;
        v.baddr = '0; v.bblen = '0;
        return v;
    endfunction

    // Runs one job from a negedge; fifo, memory and response models live here.
    task automatic run_job(input vec_t v);
        int   cyc = 0, after = -1, req_age = 0, bidx = 0, binb = 0;
        logic resp_due = 1'b0, popped = 1'b0, stall = 1'b0, prev_wl = 1'b0;
        logic [511:0] prev_wd = '0;
        got_addr.delete(); got_blen.delete();
        pops = 0; beats = 0; ack_cyc = -1; first_wv = -1; last_hs = -1;
        done_cnt = 0; err_at_done = 1'b0;
        while (cyc < 600 && (after < 0 || cyc < after)) begin
            bus.cfg_start  = (cyc == 0);
            bus.cfg_addr   = v.addr;
            bus.cfg_len    = v.len;
            bus.fifo_empty = (v.fmode != 0) && (cyc % 3 == 2);
            bus.mem_wready = (v.wmode == 0) ? 1'b1 : ((cyc % 2) == 1);
            if (bus.mem_req) req_age++; else req_age = 0;
            bus.mem_req_ack = bus.mem_req && (req_age > v.ackdly);
            bus.mem_bvalid  = resp_due;
            bus.mem_berr    = resp_due && (bidx - 1 == v.berr_b);
            resp_due = 1'b0;
            if (popped) bus.fifo_data = gen_word(pops - 1);
            popped = 1'b0;
            #1;
            if (bus.mem_req && bus.mem_req_ack) begin
                got_addr.push_back(bus.mem_addr);
                got_blen.push_back(bus.mem_blen);
                if (ack_cyc < 0) ack_cyc = cyc;
                req_age = 0;
            end
            if (bus.fifo_rd_en) begin
                chk("pop_when_empty", bus.fifo_empty, 1'b0);
                pops++;
                popped = 1'b1;
            end
            if (bus.mem_wvalid) begin
                if (first_wv < 0) first_wv = cyc;
                if (stall) begin
                    chk_w("wdata_stable", bus.mem_wdata, prev_wd);
                    chk("wlast_stable", bus.mem_wlast, prev_wl);
                end
                if (bus.mem_wready) begin
                    chk_w("wdata", bus.mem_wdata, exp_word(beats));
                    beats++; binb++; last_hs = cyc;
                    if (bus.mem_wlast) begin
                        if (bidx < got_blen.size())
                            chk("burst_beats", binb, got_blen[bidx] + 7'd1);
                        binb = 0; bidx++; resp_due = 1'b1;
                    end
                end
                stall   = !bus.mem_wready;
                prev_wd = bus.mem_wdata;
                prev_wl = bus.mem_wlast;
            end else begin
                stall = 1'b0;
            end
            if (bus.done) begin
                done_cnt++;
                if (after < 0) begin
                    err_at_done = bus.err;
                    after = cyc + 4;
                end
            end
            @(negedge clk);
            cyc++;
        end
        bus.cfg_start = 1'b0; bus.mem_req_ack = 1'b0; bus.mem_bvalid = 1'b0; bus.mem_berr = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = mk(32'h0000_1000,  4, 0, 0, 0, -1, 1,  4, 1'b0);
        vecs[0].baddr[0] = 32'h1000; vecs[0].bblen[0] = 7'd3;
        vecs[1] = mk(32'h0000_1F80, 42, 0, 0, 0, -1, 4, 42, 1'b0);
        vecs[1].baddr[0] = 32'h1F80; vecs[1].bblen[0] = 7'd1;
        vecs[1].baddr[1] = 32'h2000; vecs[1].bblen[1] = 7'd15;
        vecs[1].baddr[2] = 32'h2400; vecs[1].bblen[2] = 7'd15;
        vecs[1].baddr[3] = 32'h2800; vecs[1].bblen[3] = 7'd7;
        vecs[2] = mk(32'h0000_0040, 20, 1, 1, 2, -1, 2, 20, 1'b0);
        vecs[2].baddr[0] = 32'h0040; vecs[2].bblen[0] = 7'd15;
        vecs[2].baddr[1] = 32'h0440; vecs[2].bblen[1] = 7'd3;
        vecs[3] = mk(32'h0000_3000, 24, 0, 0, 0,  0, 1, 16, 1'b1);
        vecs[3].baddr[0] = 32'h3000; vecs[3].bblen[0] = 7'd15;
        vecs[4] = mk(32'h0000_0FC5,  3, 0, 0, 0, -1, 2,  3, 1'b0);
        vecs[4].baddr[0] = 32'h0FC0; vecs[4].bblen[0] = 7'd0;
        vecs[4].baddr[1] = 32'h1000; vecs[4].bblen[1] = 7'd1;

        rst = 1'b1;
        bus.cfg_start = 1'b0; bus.cfg_addr = '0; bus.cfg_len = '0;
        bus.fifo_empty = 1'b1; bus.fifo_data = '0;
        bus.mem_req_ack = 1'b0; bus.mem_wready = 1'b0; bus.mem_bvalid = 1'b0; bus.mem_berr = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_err", bus.err, 1'b0);
        chk("rst_rd_en", bus.fifo_rd_en, 1'b0);
        chk("rst_req", bus.mem_req, 1'b0);
        chk("rst_wvalid", bus.mem_wvalid, 1'b0);
        chk("rst_wlast", bus.mem_wlast, 1'b0);
        chk("rst_addr", bus.mem_addr, 32'h0);
        chk("rst_blen", bus.mem_blen, 7'h0);
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            run_job(vecs[i]);
            chk($sformatf("v%0d_nbursts", i), got_addr.size(), vecs[i].nb);
            for (int b = 0; b < vecs[i].nb; b++) begin
                if (b < got_addr.size()) begin
                    chk($sformatf("v%0d_b%0d_addr", i, b), got_addr[b], vecs[i].baddr[b]);
                    chk($sformatf("v%0d_b%0d_blen", i, b), got_blen[b], vecs[i].bblen[b]);
                end
            end
            chk($sformatf("v%0d_beats", i), beats, vecs[i].beats);
            chk($sformatf("v%0d_pops", i), pops, vecs[i].beats);
            chk($sformatf("v%0d_done_pulses", i), done_cnt, 1);
            chk($sformatf("v%0d_err", i), err_at_done, vecs[i].err);
            chk($sformatf("v%0d_busy_end", i), bus.busy, 1'b0);
            if (i == 0) begin
                chk("first_wvalid_latency", first_wv - ack_cyc, 3);
                chk("back_to_back", last_hs - first_wv, 3);
            end
            if (i == 3) chk("err_sticky", bus.err, 1'b1);
        end

        // Zero-length job, then a start coinciding with its done pulse.
        bus.cfg_addr = 32'h1000; bus.cfg_len = '0; bus.cfg_start = 1'b1;
        bus.fifo_empty = 1'b0;
        #1 chk("len0_no_req_c0", bus.mem_req, 1'b0);
        @(negedge clk);
        #1;
        chk("len0_done", bus.done, 1'b1);
        chk("len0_no_req", bus.mem_req, 1'b0);
        chk("len0_no_pop", bus.fifo_rd_en, 1'b0);
        @(negedge clk);
        bus.cfg_start = 1'b0;
        #1;
        chk("start_on_done_ignored", bus.done, 1'b0);
        chk("start_on_done_no_busy", bus.busy, 1'b0);
        chk("start_on_done_no_req", bus.mem_req, 1'b0);
        @(negedge clk);

        // Reset in the middle of a data phase.
        begin
            logic seen;
            seen = 1'b0;
            bus.cfg_addr = 32'h0; bus.cfg_len = 16'd8; bus.cfg_start = 1'b1;
            bus.mem_wready = 1'b0; bus.fifo_empty = 1'b0;
            @(negedge clk);
            bus.cfg_start = 1'b0;
            for (int c = 0; c < 20 && !seen; c++) begin
                bus.mem_req_ack = bus.mem_req;
                #1;
                if (bus.mem_wvalid) seen = 1'b1;
                @(negedge clk);
            end
            chk("rst_mid_reached_data", seen, 1'b1);
            bus.mem_req_ack = 1'b0;
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            #1;
            chk("mid_rst_busy", bus.busy, 1'b0);
            chk("mid_rst_wvalid", bus.mem_wvalid, 1'b0);
            chk("mid_rst_wlast", bus.mem_wlast, 1'b0);
            chk("mid_rst_rd_en", bus.fifo_rd_en, 1'b0);
            chk("mid_rst_req", bus.mem_req, 1'b0);
            chk("mid_rst_addr", bus.mem_addr, 32'h0);
            chk("mid_rst_blen", bus.mem_blen, 7'h0);
            chk_w("mid_rst_wdata", bus.mem_wdata, '0);
            done_cnt = 0;
            for (int c = 0; c < 6; c++) begin
                @(negedge clk);
                #1;
                if (bus.done) done_cnt++;
            end
            chk("mid_rst_no_done", done_cnt, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
